// File: rtl/pf_pkg.sv
// Shared types and constants for the camera pixel-capture front-end.
// Holds the capture FSM encoding, RGB332 field layout and default counter widths.
package pf_pkg;

  typedef enum logic [1:0] {
    CAP_IDLE   = 2'd0,
    CAP_SYNC   = 2'd1,
    CAP_ACTIVE = 2'd2
  } cap_state_e;

  localparam int COL_W_DEF = 10;
  localparam int ROW_W_DEF = 9;
  localparam int CNT_W_DEF = 16;

  localparam int R332_LSB = 5;
  localparam int G332_LSB = 2;
  localparam int B332_LSB = 0;

  // hi_rg = {R5[4:2], G6[5:3]} taken from the high byte; lo_b = B5[4:3]
  function automatic logic [7:0] rgb332(input logic [5:0] hi_rg, input logic [1:0] lo_b);
    logic [7:0] p;
    p = '0;
    p[R332_LSB +: 3] = hi_rg[5:3];
    p[G332_LSB +: 3] = hi_rg[2:0];
    p[B332_LSB +: 2] = lo_b;
    return p;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers one camera sync line and flags its rising/falling edges
// relative to the previous registered sample.
module cam_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_lvl;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lvl  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_lvl  <= i_sig;
      r_prev <= r_lvl;
    end
  end

  assign o_lvl  = r_lvl;
  assign o_rise = r_lvl & ~r_prev;
  assign o_fall = ~r_lvl & r_prev;

endmodule

// File: rtl/cam_pixel_capture.sv
// Camera byte-bus front-end: pairs RGB565 bytes into RGB332 pixels with
// coordinates, frame/line markers and an odd-byte framing error flag.
module cam_pixel_capture
  import pf_pkg::*;
#(
  parameter int COL_W = COL_W_DEF,
  parameter int ROW_W = ROW_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       cam_data,
  input  logic             cam_vsync,
  input  logic             cam_href,
  output logic [7:0]       pix_data,
  output logic             pix_valid,
  output logic [COL_W-1:0] col_count,
  output logic [ROW_W-1:0] row_count,
  output logic             line_end,
  output logic             frame_start,
  output logic             frame_end,
  output logic [CNT_W-1:0] frame_pixels,
  output logic             byte_err
);

  logic w_vs, w_vs_rise, w_vs_fall;
  logic w_hs, w_hs_fall, w_unused_hs_rise;

  cam_sync_edge u_vs (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (cam_vsync),
    .o_lvl  (w_vs),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  cam_sync_edge u_hs (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_sig  (cam_href),
    .o_lvl  (w_hs),
    .o_rise (w_unused_hs_rise),
    .o_fall (w_hs_fall)
  );

  cap_state_e       r_state, w_state_nxt;
  logic [7:0]       r_sdata;
  logic [5:0]       r_hi;
  logic             r_phase;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [CNT_W-1:0] r_cnt;
  logic             w_fs, w_fe, w_le, w_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= CAP_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A VSYNC rise while HREF is still high closes the line as well as the frame.
  always_comb begin
    w_state_nxt = r_state;
    w_fs        = 1'b0;
    w_fe        = 1'b0;
    w_le        = 1'b0;
    w_byte      = 1'b0;
    if (!enable) begin
      w_state_nxt = CAP_IDLE;
    end else begin
      case (r_state)
        CAP_IDLE: if (w_vs) w_state_nxt = CAP_SYNC;
        CAP_SYNC: if (w_vs_fall) begin
          w_state_nxt = CAP_ACTIVE;
          w_fs        = 1'b1;
        end
        CAP_ACTIVE: if (w_vs_rise) begin
          w_state_nxt = CAP_SYNC;
          w_fe        = 1'b1;
          w_le        = w_hs | w_hs_fall;
        end else begin
          w_le   = w_hs_fall;
          w_byte = w_hs;
        end
        default: w_state_nxt = CAP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sdata      <= '0;
      r_hi         <= '0;
      r_phase      <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_cnt        <= '0;
      pix_data     <= '0;
      pix_valid    <= 1'b0;
      col_count    <= '0;
      row_count    <= '0;
      line_end     <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      frame_pixels <= '0;
      byte_err     <= 1'b0;
    end else begin
      r_sdata     <= cam_data;
      pix_valid   <= 1'b0;
      line_end    <= w_le;
      frame_start <= w_fs;
      frame_end   <= w_fe;
      if (w_fs) begin
        r_col    <= '0;
        r_row    <= '0;
        r_cnt    <= '0;
        r_phase  <= 1'b0;
        byte_err <= 1'b0;
      end
      if (w_byte) begin
        if (!r_phase) begin
          r_hi    <= {r_sdata[7:5], r_sdata[2:0]};
          r_phase <= 1'b1;
        end else begin
          pix_data  <= rgb332(r_hi, r_sdata[4:3]);
          pix_valid <= 1'b1;
          col_count <= r_col;
          row_count <= r_row;
          r_col     <= (r_col == '1) ? r_col : r_col + 1'b1;
          r_cnt     <= (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
          r_phase   <= 1'b0;
        end
      end
      if (w_le) begin
        r_row <= (r_row == '1) ? r_row : r_row + 1'b1;
        r_col <= '0;
        if (r_phase) begin
          byte_err <= 1'b1;
          r_phase  <= 1'b0;
        end
      end
      if (w_fe) frame_pixels <= r_cnt;
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Self-checking bench for cam_pixel_capture: line/frame-level reference model
// with random pixel bytes, directed framing corner cases and a pulse monitor.
module tb_cam_pixel_capture;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic        cam_vsync = 1'b0, cam_href = 1'b0;
  logic [7:0]  cam_data = '0;
  logic [7:0]  pix_data;
  logic        pix_valid, line_end, frame_start, frame_end, byte_err;
  logic [9:0]  col_count;
  logic [8:0]  row_count;
  logic [15:0] frame_pixels;

  cam_pixel_capture dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cam_data     (cam_data),
    .cam_vsync    (cam_vsync),
    .cam_href     (cam_href),
    .pix_data     (pix_data),
    .pix_valid    (pix_valid),
    .col_count    (col_count),
    .row_count    (row_count),
    .line_end     (line_end),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .frame_pixels (frame_pixels),
    .byte_err     (byte_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; int col; int row; int cyc; } pix_t;
  typedef struct { int cnt; logic err; logic le; } fe_t;

  pix_t       pix_q[$];
  fe_t        fe_q[$];
  logic [7:0] lb[$];

  int   n_chk = 0, n_err = 0;
  int   le_exp = 0, le_seen = 0, fs_exp = 0, fs_seen = 0;
  int   exp_row = 0, exp_cnt = 0;
  logic exp_err = 1'b0, cap_on = 1'b0;
  logic rst_q = 1'b0, en_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // RGB565 word -> RGB332 by truncating each channel to its top bits
  function automatic logic [7:0] to332(input logic [15:0] w);
    int r5, g6, b5;
    r5 = int'(w[15:11]);
    g6 = int'(w[10:5]);
    b5 = int'(w[4:0]);
    return 8'((r5 / 4) * 32 + (g6 / 8) * 4 + b5 / 8);
  endfunction

  task automatic drive(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    rst_n     = rst_q;
    enable    = en_q;
    cam_vsync = v;
    cam_href  = h;
    cam_data  = d;
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_pix_data"},  32'(pix_data), 0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 0);
    chk({tag, "_col"},       32'(col_count), 0);
    chk({tag, "_row"},       32'(row_count), 0);
    chk({tag, "_line_end"},  32'(line_end), 0);
    chk({tag, "_fstart"},    32'(frame_start), 0);
    chk({tag, "_fend"},      32'(frame_end), 0);
    chk({tag, "_fpixels"},   32'(frame_pixels), 0);
    chk({tag, "_byte_err"},  32'(byte_err), 0);
  endtask

  task automatic fill_rand(input int n);
    lb.delete();
    repeat (n) lb.push_back(8'($urandom));
  endtask

  // mode 0: HREF falls alone; 1: VSYNC rises as HREF falls; 2: VSYNC rises with HREF high.
  // kind 1 drops enable / kind 2 pulses reset just before byte index 'cut'.
  task automatic send_line(input int mode, input int cut, input int kind);
    int   n;
    pix_t p;
    fe_t  f;
    n = lb.size();
    for (int i = 0; i < n; i++) begin
      if (kind != 0 && i == cut) begin
        if (kind == 1) en_q = 1'b0;
        else           rst_q = 1'b0;
        cap_on = 1'b0;
      end
      if (kind == 2 && i == cut + 1) rst_q = 1'b1;
      drive(1'b0, 1'b1, lb[i]);
      if (kind == 2 && i == cut + 1) rst_check("midrst");
      if (cap_on && (i % 2 == 1)) begin
        p.d   = to332({lb[i-1], lb[i]});
        p.col = (i / 2 > 1023) ? 1023 : i / 2;
        p.row = exp_row;
        p.cyc = cyc + 2;
        pix_q.push_back(p);
        if (exp_cnt < 65535) exp_cnt++;
      end
    end
    if (cap_on) begin
      le_exp++;
      if (n % 2 == 1) exp_err = 1'b1;
      if (exp_row < 511) exp_row++;
      if (mode != 0) begin
        f.cnt = exp_cnt; f.err = exp_err; f.le = 1'b1;
        fe_q.push_back(f);
        cap_on = 1'b0;
      end
    end
    case (mode)
      0: drive(1'b0, 1'b0, 8'($urandom));
      1: drive(1'b1, 1'b0, 8'($urandom));
      default: begin
        drive(1'b1, 1'b1, 8'($urandom));
        drive(1'b1, 1'b1, 8'($urandom));
        drive(1'b1, 1'b0, 8'($urandom));
      end
    endcase
  endtask

  task automatic vsync_pulse(input logic start_high, input int hi);
    fe_t f;
    if (!start_high && cap_on) begin
      f.cnt = exp_cnt; f.err = exp_err; f.le = 1'b0;
      fe_q.push_back(f);
      cap_on = 1'b0;
    end
    repeat (hi) drive(1'b1, 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 8'($urandom));
    if (en_q && rst_q) begin
      fs_exp++;
      cap_on  = 1'b1;
      exp_row = 0;
      exp_cnt = 0;
      exp_err = 1'b0;
    end
  endtask

  task automatic chkpt(input string tag);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    chk({tag, "_line_ends"},   le_seen, le_exp);
    chk({tag, "_frame_starts"}, fs_seen, fs_exp);
    chk({tag, "_pix_missing"}, pix_q.size(), 0);
    chk({tag, "_fend_missing"}, fe_q.size(), 0);
  endtask

  initial begin : monitor
    pix_t e;
    fe_t  f;
    forever begin
      @(negedge clk);
      if (pix_valid) begin
        if (pix_q.size() == 0) chk("pix_extra", 32'(pix_valid), 0);
        else begin
          e = pix_q.pop_front();
          chk("pix_data", 32'(pix_data), 32'(e.d));
          chk("pix_col",  32'(col_count), e.col);
          chk("pix_row",  32'(row_count), e.row);
          chk("pix_cyc",  cyc, e.cyc);
        end
      end
      if (line_end) le_seen++;
      if (frame_start) begin
        fs_seen++;
        chk("fstart_err_clr", 32'(byte_err), 0);
      end
      if (frame_end) begin
        if (fe_q.size() == 0) chk("fend_extra", 32'(frame_end), 0);
        else begin
          f = fe_q.pop_front();
          chk("fend_pixels",  32'(frame_pixels), f.cnt);
          chk("fend_byte_err", 32'(byte_err), 32'(f.err));
          chk("fend_line_end", 32'(line_end), 32'(f.le));
        end
      end
    end
  end

  initial begin : stim
    int nl;
    int md;
    rst_q = 1'b0;
    en_q  = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'h00);
    rst_check("reset");
    rst_q = 1'b1;
    drive(1'b0, 1'b0, 8'h00);

    // directed pair F81F / 07E0
    vsync_pulse(1'b0, 4);
    lb = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
    send_line(0, -1, 0);
    vsync_pulse(1'b0, 4);
    chkpt("t1");

    // 3 lines x 8 bytes
    repeat (3) begin fill_rand(8); send_line(0, -1, 0); end
    vsync_pulse(1'b0, 4);
    chkpt("t2");

    // odd line sets sticky byte_err, cleared by the next frame_start
    fill_rand(5); send_line(0, -1, 0);
    fill_rand(4); send_line(0, -1, 0);
    drive(1'b0, 1'b0, 8'h00);
    chk("err_sticky", 32'(byte_err), 1);
    vsync_pulse(1'b0, 4);
    chkpt("t3");
    chk("err_cleared", 32'(byte_err), 0);

    // enable dropped mid-line, restored mid-frame
    fill_rand(8); send_line(0, 3, 1);
    en_q = 1'b1;
    fill_rand(6); send_line(0, -1, 0);
    vsync_pulse(1'b0, 4);
    fill_rand(4); send_line(0, -1, 0);
    vsync_pulse(1'b0, 4);
    chkpt("t4");

    // one-cycle reset mid-line
    fill_rand(8); send_line(0, 3, 2);
    fill_rand(4); send_line(0, -1, 0);
    vsync_pulse(1'b0, 4);
    fill_rand(4); send_line(0, -1, 0);
    vsync_pulse(1'b0, 4);
    chkpt("t5");

    // VSYNC rise coinciding with HREF fall, and VSYNC rise while HREF high
    fill_rand(6); send_line(1, -1, 0);
    vsync_pulse(1'b1, 4);
    fill_rand(3); send_line(0, -1, 0);
    fill_rand(5); send_line(2, -1, 0);
    vsync_pulse(1'b1, 4);
    chkpt("t6");

    // column saturation
    fill_rand(2050); send_line(0, -1, 0);
    vsync_pulse(1'b0, 4);
    chkpt("t7");

    // row saturation
    repeat (515) begin fill_rand(2); send_line(0, -1, 0); end
    vsync_pulse(1'b0, 4);
    chkpt("t8");

    // random frames
    repeat (6) begin
      nl = int'($urandom_range(1, 4));
      for (int l = 0; l < nl; l++) begin
        md = (l == nl - 1) ? int'($urandom_range(0, 2)) : 0;
        fill_rand(int'($urandom_range(1, 12)));
        send_line(md, -1, 0);
      end
      vsync_pulse(md != 0, 3);
    end
    chkpt("t9");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Camera front-end for ML harvest-detection mode.
- Takes the raw 8-bit camera byte bus with VSYNC/HREF, sampled on clk, where clk is the camera pixel clock.
- Assembles RGB565 byte pairs and emits one RGB332 pixel per pair with a valid strobe.
- Produces frame/line markers, pixel coordinates and framing-error status for the downstream green-pixel classifier.

Parameters:
- COL_W, 10, width of column counter (max 1023 pixels/line).
- ROW_W, 9, width of row counter (max 511 lines/frame).
- CNT_W, 16, width of per-frame pixel count.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- enable  in  1  capture enable (tied to ML mode select)
- cam_data  in  8  camera byte bus
- cam_vsync  in  1  frame sync, high between frames
- cam_href  in  1  line valid, high during active bytes
- pix_data  out  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}
- pix_valid  out  1  one-cycle strobe, pix_data valid
- col_count  out  COL_W  column index of current pix_data
- row_count  out  ROW_W  row index of current pix_data
- line_end  out  1  one-cycle pulse at HREF fall
- frame_start  out  1  one-cycle pulse at VSYNC fall
- frame_end  out  1  one-cycle pulse at VSYNC rise
- frame_pixels  out  CNT_W  pixel total of last completed frame
- byte_err  out  1  sticky: odd byte count seen on some line of current frame

Behaviour:
- Reset is synchronous on rst_n low. Clock is clk.
- Reset values: all outputs 0, FSM in IDLE, byte phase 0, counters 0.
- Input stage: cam_data, cam_vsync and cam_href are registered once (s_data, s_vs, s_hs). Edges are detected against previous s_vs/s_hs.
- FSM states:
  - IDLE: waits for s_vs high; discards any partial frame. IDLE -> SYNC when s_vs=1 and enable=1.
  - SYNC: waits for VSYNC fall. SYNC -> ACTIVE on s_vs fall; pulse frame_start; clear row, col, phase, byte_err and running pixel count.
  - ACTIVE: capturing. ACTIVE -> SYNC on s_vs rise; pulse frame_end; frame_pixels <= running count.
- Any state -> IDLE when enable=0, next cycle. Pulses are suppressed and pix_valid=0 while disabled. Re-enable always waits for a complete VSYNC high period before any capture.
- Byte assembly in ACTIVE with s_hs=1:
  - phase 0: latch hi byte.
  - phase 1: form RGB565 {hi,lo}; pix_data <= {hi[7:5], hi[2:0], lo[4:3]} (R5 top 3, G6 top 3, B5 top 2).
  - phase toggles every active byte.
- Latency: the second byte of a pair on cam_data at cycle N gives pix_valid high at cycle N+2.
- col_count/row_count are the coordinates of the emitted pixel. col increments after each pix_valid.
- Saturation: col saturates at 2^COL_W-1, row at 2^ROW_W-1, running count at 2^CNT_W-1; none wrap.
- HREF fall in ACTIVE:
  - pulse line_end; row increments (saturating); col <= 0.
  - If phase=1 (odd byte count): drop the half pixel, set byte_err, phase <= 0.
- s_hs=1 outside ACTIVE: ignored; no pixels, no line_end.
- Simultaneous VSYNC rise and HREF fall in the same cycle: line_end and frame_end both pulse. The odd-byte check applies before frame_pixels is latched. The half pixel is not counted.
- VSYNC rise while s_hs=1: treated as HREF fall (line_end plus frame_end).
- byte_err stays set until the next frame_start.
- Reset mid-frame: all outputs return to 0 next cycle. The frame in progress is discarded, and frame_pixels clears to 0.

Decomposition:
- Shared package pf_pkg holds:
  - state enum CAP_IDLE/CAP_SYNC/CAP_ACTIVE;
  - RGB332 field positions;
  - default COL_W/ROW_W/CNT_W.
- One natural sub-module: cam_sync_edge, which registers vsync/href and outputs the registered level plus rise/fall pulses.

Test Plan:
- Reset, enable=1, vsync high 4 cycles then low, one line of 4 bytes 0xF8,0x1F,0x07,0xE0 -> frame_start once; pix_data 0xE3 then 0x1C; col 0,1; row 0; pix_valid 2 cycles after 2nd and 4th bytes; line_end once.
- Frame of 3 lines x 8 bytes, then vsync high -> frame_end pulse; frame_pixels=12; row_count 0..2; byte_err=0.
- Line with 5 bytes -> 2 pixels only; byte_err=1 until the next frame_start, then 0.
- Enable low mid-line, then high mid-frame -> no pix_valid until the next full vsync high/low; then normal capture.
- rst_n low for 1 cycle mid-line -> all outputs 0 next cycle; capture resumes only after a new VSYNC period.
- vsync rises in the same cycle href falls -> line_end and frame_end asserted together; frame_pixels includes all completed pairs.
